sme_match_ctrl: RTL

Sequencing controller for the string-matching engine. Loads a pattern byte stream into a local buffer, starts the failure-function unit, and holds it active until its table is valid. It then runs KMP matching over a text byte stream using that table and reports every match end position. It sits between the host-side byte streams and the failure-function datapath, and owns that unit's start/valid handshake.

---
 rtl/sme_match_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sme_match_ctrl.sv
// KMP match sequencer: loads a pattern, runs the failure-function unit, then scans text and reports match end positions.
// Latency: 1 pattern byte/cycle; 1 text byte/cycle, +1 stall per fallback; match_valid/done registered one edge after the comparison.
// Backpressure: pat_ready in IDLE/LOAD only, txt_ready in MATCH from registers only. SME_OVERLAP_EN reports overlapping matches.
module sme_match_ctrl #(
    parameter int MAX_PATTERN = 32,
    parameter int PAT_AW      = 5,
    parameter int POS_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pat_valid,
    input  logic [7:0]                  pat_data,
    input  logic                        pat_last,
    output logic                        pat_ready,
    output logic                        ff_start,
    output logic [MAX_PATTERN*8-1:0]    ff_pattern,
    output logic [PAT_AW-1:0]           ff_last_idx,
    input  logic [PAT_AW*MAX_PATTERN-1:0] ff_table,
    input  logic                        ff_done,
    input  logic                        txt_valid,
    input  logic [7:0]                  txt_data,
    input  logic                        txt_last,
    output logic                        txt_ready,
    output logic                        match_valid,
    output logic [POS_W-1:0]            match_pos,
    output logic [POS_W-1:0]            match_cnt,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FF_WAIT, S_MATCH, S_DONE} state_t;

    localparam logic [PAT_AW:0] WR_FULL = (PAT_AW+1)'(MAX_PATTERN);

    state_t             state, state_nxt;
    logic [PAT_AW:0]    wr_idx;
    logic [PAT_AW-1:0]  j;
    logic [POS_W-1:0]   txt_cnt;
    logic [7:0]         cur_byte;
    logic [POS_W-1:0]   cur_pos;
    logic               cur_last;
    logic               cur_full;

    logic               pat_fire, txt_fire;
    logic [PAT_AW:0]    wr_pos;
    logic               room;
    logic [7:0]         pat_byte_j;
    logic [PAT_AW-1:0]  j_m1, fb_j, restart_j;
    logic               byte_eq, at_end, resolve, hit;

    assign pat_fire = pat_valid && pat_ready;
    assign txt_fire = txt_valid && txt_ready;

    // A load always restarts at byte 0; wr_idx sticks at MAX_PATTERN so overflow bytes are dropped.
    assign wr_pos = (state == S_IDLE) ? '0 : wr_idx;
    assign room   = (wr_pos < WR_FULL);

    assign pat_byte_j = ff_pattern[int'(j)*8 +: 8];
    assign j_m1       = j - PAT_AW'(1);
    assign fb_j       = ff_table[int'(j_m1)*PAT_AW +: PAT_AW];
`ifdef SME_OVERLAP_EN
    assign restart_j  = ff_table[int'(ff_last_idx)*PAT_AW +: PAT_AW];
`else
    assign restart_j  = '0;
`endif

    assign byte_eq = cur_full && (pat_byte_j == cur_byte);
    assign at_end  = (j == ff_last_idx);
    assign resolve = cur_full && (byte_eq || (j == '0));
    assign hit     = byte_eq && at_end;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (pat_fire) state_nxt = pat_last ? S_FF_WAIT : S_LOAD;
            S_LOAD:    if (pat_fire && pat_last) state_nxt = S_FF_WAIT;
            S_FF_WAIT: if (ff_done) state_nxt = S_MATCH;
            S_MATCH:   if (resolve && cur_last) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pat_ready = (state == S_IDLE) || (state == S_LOAD);
        ff_start  = (state == S_FF_WAIT) || (state == S_MATCH);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        txt_ready = (state == S_MATCH) && (!cur_full || resolve);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx      <= '0;
            ff_pattern  <= '0;
            ff_last_idx <= '0;
            j           <= '0;
            txt_cnt     <= '0;
            cur_byte    <= '0;
            cur_pos     <= '0;
            cur_last    <= 1'b0;
            cur_full    <= 1'b0;
            match_valid <= 1'b0;
            match_pos   <= '0;
            match_cnt   <= '0;
        end else begin
            match_valid <= 1'b0;
            if (pat_fire) begin
                if (room) ff_pattern[int'(wr_pos[PAT_AW-1:0])*8 +: 8] <= pat_data;
                wr_idx <= wr_pos + (PAT_AW+1)'(room);
                if (pat_last) begin
                    ff_last_idx <= room ? wr_pos[PAT_AW-1:0] : PAT_AW'(MAX_PATTERN-1);
                    match_cnt   <= '0;
                    txt_cnt     <= '0;
                    j           <= '0;
                    cur_full    <= 1'b0;
                end
            end
            if (state == S_MATCH) begin
                if (txt_fire) begin
                    cur_byte <= txt_data;
                    cur_pos  <= txt_cnt;
                    cur_last <= txt_last;
                    txt_cnt  <= txt_cnt + POS_W'(1);
                    cur_full <= 1'b1;
                end else if (resolve) begin
                    cur_full <= 1'b0;
                end
                // One comparison per cycle; a fallback keeps cur_full set so the byte is retried.
                if (cur_full) begin
                    if (hit) begin
                        match_valid <= 1'b1;
                        match_pos   <= cur_pos;
                        if (match_cnt != '1) match_cnt <= match_cnt + POS_W'(1);
                        j <= restart_j;
                    end else if (byte_eq) begin
                        j <= j + PAT_AW'(1);
                    end else if (j != '0) begin
                        j <= fb_j;
                    end
                end
            end
        end
    end

endmodule
